csr_snapshot_arbiter: RTL and testbench

Shares the single combinational CSR read port between the core pipeline and a host/debug requester.
- The core always has priority.
- Host requests are 64-bit counter snapshots (mhpmcounter0/3/4 family).
- On RV32 it sequences a rollover-safe HI/LO/HI read with bounded retry. On RV64 it does a single read.
- It sits between the core's CSR read stage and the CSR file.

---
 rtl/csr_snapshot_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_csr_snapshot_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_snapshot_arbiter.sv
// Shares the CSR read port between the core (priority) and a host 64-bit counter snapshot sequencer.
// Optional starvation guard: define CSR_ARB_STARVE_GUARD_EN to add core_stall_o and a forced host grant.
module csr_snapshot_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int CSR_ADDR_WIDTH = 12,
    parameter int MAX_RETRY      = 3,
    parameter int STARVE_LIMIT   = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      core_ren_i,
    input  logic [CSR_ADDR_WIDTH-1:0] core_raddr_i,
    output logic [DATA_WIDTH-1:0]     core_rdata_o,
    input  logic                      host_req_valid_i,
    output logic                      host_req_ready_o,
    input  logic [CSR_ADDR_WIDTH-1:0] host_req_addr_i,
    output logic                      host_rsp_valid_o,
    input  logic                      host_rsp_ready_i,
    output logic [63:0]               host_rsp_data_o,
    output logic                      host_rsp_err_o,
`ifdef CSR_ARB_STARVE_GUARD_EN
    output logic                      core_stall_o,
`endif
    output logic [CSR_ADDR_WIDTH-1:0] csr_raddr_o,
    input  logic [DATA_WIDTH-1:0]     csr_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_HI1,
        S_RD_LO,
        S_RD_HI2,
        S_RSP
    } state_t;

    localparam logic [CSR_ADDR_WIDTH-1:0] HI_OFS      = CSR_ADDR_WIDTH'(128);
    localparam logic [3:0]                MAX_RETRY_L = 4'(MAX_RETRY);

    state_t                      state_q, state_d;
    logic [CSR_ADDR_WIDTH-1:0]   lo_addr_q, lo_addr_d;
    logic [CSR_ADDR_WIDTH-1:0]   hi_addr_q, hi_addr_d;
    logic [31:0]                 hi1_q, hi1_d;
    logic [31:0]                 lo_q, lo_d;
    logic [3:0]                  retry_q, retry_d;
    logic [63:0]                 rsp_data_q, rsp_data_d;
    logic                        rsp_err_q, rsp_err_d;
    logic [CSR_ADDR_WIDTH-1:0]   seq_addr;
    logic                        host_gnt;
    logic                        in_rd;
    logic [31:0]                 rd32;

    assign in_rd = (state_q == S_RD_HI1) || (state_q == S_RD_LO) || (state_q == S_RD_HI2);
    assign rd32  = csr_rdata_i[31:0];

`ifdef CSR_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_cnt_q;
    logic          force_gnt;

    // After STARVE_LIMIT consecutive blocked read cycles the host takes one cycle.
    assign force_gnt    = in_rd && core_ren_i && (starve_cnt_q == CW'(STARVE_LIMIT));
    assign core_stall_o = force_gnt;
    assign host_gnt     = !core_ren_i || force_gnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_cnt_q <= '0;
        end else if (in_rd && !host_gnt) begin
            starve_cnt_q <= starve_cnt_q + CW'(1);
        end else begin
            starve_cnt_q <= '0;
        end
    end
`else
    assign host_gnt = !core_ren_i;
`endif

    assign csr_raddr_o      = host_gnt ? seq_addr : core_raddr_i;
    assign core_rdata_o     = csr_rdata_i;
    assign host_req_ready_o = (state_q == S_IDLE) && !rst_i;
    assign host_rsp_valid_o = (state_q == S_RSP);
    assign host_rsp_data_o  = rsp_data_q;
    assign host_rsp_err_o   = rsp_err_q;

    always_comb begin
        state_d    = state_q;
        lo_addr_d  = lo_addr_q;
        hi_addr_d  = hi_addr_q;
        hi1_d      = hi1_q;
        lo_d       = lo_q;
        retry_d    = retry_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        seq_addr   = lo_addr_q;
        case (state_q)
            S_IDLE: begin
                if (host_req_valid_i) begin
                    lo_addr_d = host_req_addr_i;
                    hi_addr_d = host_req_addr_i | HI_OFS;
                    retry_d   = '0;
                    if (host_req_addr_i[7]) begin
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                        state_d    = S_RSP;
                    end else begin
                        state_d = (DATA_WIDTH == 64) ? S_RD_LO : S_RD_HI1;
                    end
                end
            end
            S_RD_HI1: begin
                seq_addr = hi_addr_q;
                if (host_gnt) begin
                    hi1_d   = rd32;
                    state_d = S_RD_LO;
                end
            end
            S_RD_LO: begin
                seq_addr = lo_addr_q;
                if (host_gnt) begin
                    lo_d = rd32;
                    if (DATA_WIDTH == 64) begin
                        rsp_data_d = 64'(csr_rdata_i);
                        rsp_err_d  = 1'b0;
                        state_d    = S_RSP;
                    end else begin
                        state_d = S_RD_HI2;
                    end
                end
            end
            S_RD_HI2: begin
                seq_addr = hi_addr_q;
                if (host_gnt) begin
                    if (rd32 == hi1_q) begin
                        rsp_data_d = {hi1_q, lo_q};
                        rsp_err_d  = 1'b0;
                        state_d    = S_RSP;
                    end else if (retry_q < MAX_RETRY_L) begin
                        hi1_d   = rd32;
                        retry_d = retry_q + 4'd1;
                        state_d = S_RD_LO;
                    end else begin
                        rsp_data_d = {rd32, lo_q};
                        rsp_err_d  = 1'b1;
                        state_d    = S_RSP;
                    end
                end
            end
            S_RSP: begin
                if (host_rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            lo_addr_q  <= '0;
            hi_addr_q  <= '0;
            hi1_q      <= '0;
            lo_q       <= '0;
            retry_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lo_addr_q  <= lo_addr_d;
            hi_addr_q  <= hi_addr_d;
            hi1_q      <= hi1_d;
            lo_q       <= lo_d;
            retry_q    <= retry_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_csr_snapshot_arbiter.sv
// Self-checking bench for csr_snapshot_arbiter: CSR file model with a HI word that can tick on reads.
module tb_csr_snapshot_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int MR = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          core_ren;
    logic [AW-1:0] core_raddr;
    logic [DW-1:0] core_rdata;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [63:0]   rsp_data;
    logic          rsp_err;
    logic [AW-1:0] csr_raddr;
    logic [DW-1:0] csr_rdata;
`ifdef CSR_ARB_STARVE_GUARD_EN
    logic          core_stall;
`endif

    csr_snapshot_arbiter #(
        .DATA_WIDTH    (DW),
        .CSR_ADDR_WIDTH(AW),
        .MAX_RETRY     (MR),
        .STARVE_LIMIT  (8)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .core_ren_i      (core_ren),
        .core_raddr_i    (core_raddr),
        .core_rdata_o    (core_rdata),
        .host_req_valid_i(req_valid),
        .host_req_ready_o(req_ready),
        .host_req_addr_i (req_addr),
        .host_rsp_valid_o(rsp_valid),
        .host_rsp_ready_i(rsp_ready),
        .host_rsp_data_o (rsp_data),
        .host_rsp_err_o  (rsp_err),
`ifdef CSR_ARB_STARVE_GUARD_EN
        .core_stall_o    (core_stall),
`endif
        .csr_raddr_o     (csr_raddr),
        .csr_rdata_i     (csr_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Counter model: HI reads h0 + min(reads, k) * step, LO is constant.
    logic [AW-1:0] lo_a, hi_a;
    logic [31:0]   lo_v, h0, step;
    int            k;
    int            hi_reads = 0;
    int            reads_base;
    int            rel;
    bit            armed;
    logic [31:0]   hi_now;
    logic [31:0]   core_obs[$];
    int            stall_cnt;

    always_comb begin
        rel    = hi_reads - reads_base;
        hi_now = h0 + step * 32'((rel < k) ? rel : k);
        if (csr_raddr == lo_a)      csr_rdata = lo_v;
        else if (csr_raddr == hi_a) csr_rdata = hi_now;
        else                        csr_rdata = 32'hC0DE_0000 | 32'(csr_raddr);
    end

    logic host_owns;
`ifdef CSR_ARB_STARVE_GUARD_EN
    assign host_owns = !core_ren || core_stall;
`else
    assign host_owns = !core_ren;
`endif

    always @(posedge clk)
        if (armed && host_owns && csr_raddr == hi_a && !rsp_valid)
            hi_reads <= hi_reads + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input logic [AW-1:0] a, input logic [31:0] hv, input logic [31:0] st,
                         input logic [31:0] lv, input int kk);
        lo_a       = a;
        hi_a       = a | 12'h080;
        h0         = hv;
        step       = st;
        lo_v       = lv;
        k          = kk;
        reads_base = hi_reads;
        armed      = 1'b0;
    endtask

    task automatic expect_snap(output logic [63:0] d, output logic e, output int lat);
        int cmp;
        logic [31:0] last;
        if (k <= MR) begin
            cmp = k + 1;
            e   = 1'b0;
        end else begin
            cmp = MR + 1;
            e   = 1'b1;
        end
        last = h0 + step * 32'(cmp - 1 + (e ? 1 : 0));
        d    = {last, lo_v};
        lat  = 1 + 2 * cmp;
    endtask

    task automatic issue(input logic [AW-1:0] a);
        int w = 0;
        while (!req_ready && w < 20) begin
            tick();
            w++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL issue_ready_timeout got=%0b want=1", req_ready);
        end
        req_addr  = a;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        armed     = 1'b1;
    endtask

    task automatic run_seq(input int s, input int len, output int n);
        core_obs.delete();
        stall_cnt = 0;
        n = 0;
        while (!rsp_valid && n < 200) begin
            core_ren   = (n >= s) && (n < s + len);
            core_raddr = 12'hB04;
            #1;
            if (core_ren) core_obs.push_back(core_rdata);
`ifdef CSR_ARB_STARVE_GUARD_EN
            if (core_stall) stall_cnt++;
`endif
            tick();
            n++;
        end
        core_ren = 1'b0;
        armed    = 1'b0;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b want=0", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", rsp_valid); end
        total++; if (rsp_data !== 64'h0) begin bad++; $display("FAIL reset_data got=%h want=0", rsp_data); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b want=0", rsp_err); end
        rst = 1'b0;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%0b want=1", req_ready); end
    endtask

    task automatic test_basic();
        int n;
        setup(12'hB00, 32'h1, 32'h1, 32'h10, 0);
        issue(12'hB00);
        run_seq(1000, 0, n);
        total++; if (n !== 3) begin bad++; $display("FAIL basic_latency got=%0d want=3", n); end
        total++; if (rsp_data !== 64'h00000001_00000010) begin bad++; $display("FAIL basic_data got=%h want=%h", rsp_data, 64'h00000001_00000010); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL basic_err got=%0b want=0", rsp_err); end
        consume();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_drop got=%0b want=0", rsp_valid); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_after got=%0b want=1", req_ready); end
    endtask

    task automatic test_retry_once();
        int n;
        setup(12'hB00, 32'h1, 32'h1, 32'h5, 1);
        issue(12'hB00);
        run_seq(1000, 0, n);
        total++; if (n !== 5) begin bad++; $display("FAIL retry1_latency got=%0d want=5", n); end
        total++; if (rsp_data !== 64'h00000002_00000005) begin bad++; $display("FAIL retry1_data got=%h want=%h", rsp_data, 64'h00000002_00000005); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL retry1_err got=%0b want=0", rsp_err); end
        consume();
    endtask

    task automatic test_retry_exhaust();
        int n;
        setup(12'hB00, 32'h1, 32'h1, 32'h7, 100);
        issue(12'hB00);
        run_seq(1000, 0, n);
        total++; if (n !== 9) begin bad++; $display("FAIL exhaust_latency got=%0d want=9", n); end
        total++; if (rsp_data !== 64'h00000005_00000007) begin bad++; $display("FAIL exhaust_data got=%h want=%h", rsp_data, 64'h00000005_00000007); end
        total++; if (rsp_err !== 1'b1) begin bad++; $display("FAIL exhaust_err got=%0b want=1", rsp_err); end
        consume();
    endtask

    task automatic test_bad_addr();
        int n;
        setup(12'hB83, 32'h1234, 32'h1, 32'h99, 0);
        issue(12'hB83);
        run_seq(1000, 0, n);
        total++; if (n !== 0) begin bad++; $display("FAIL badaddr_latency got=%0d want=0", n); end
        total++; if (rsp_data !== 64'h0) begin bad++; $display("FAIL badaddr_data got=%h want=0", rsp_data); end
        total++; if (rsp_err !== 1'b1) begin bad++; $display("FAIL badaddr_err got=%0b want=1", rsp_err); end
        total++; if (hi_reads - reads_base !== 0) begin bad++; $display("FAIL badaddr_reads got=%0d want=0", hi_reads - reads_base); end
        consume();
    endtask

    task automatic test_contention();
        int n;
        setup(12'hB00, 32'h1, 32'h1, 32'h10, 0);
        issue(12'hB00);
        run_seq(1, 5, n);
        total++; if (n !== 8) begin bad++; $display("FAIL contend_latency got=%0d want=8", n); end
        total++; if (core_obs.size() !== 5) begin bad++; $display("FAIL contend_cycles got=%0d want=5", core_obs.size()); end
        foreach (core_obs[i]) begin
            total++;
            if (core_obs[i] !== 32'hC0DE0B04) begin bad++; $display("FAIL contend_core_rdata[%0d] got=%h want=%h", i, core_obs[i], 32'hC0DE0B04); end
        end
        total++; if (rsp_data !== 64'h00000001_00000010) begin bad++; $display("FAIL contend_data got=%h want=%h", rsp_data, 64'h00000001_00000010); end
        consume();
    endtask

`ifdef CSR_ARB_STARVE_GUARD_EN
    task automatic test_starve();
        int n;
        setup(12'hB00, 32'h1, 32'h1, 32'h10, 0);
        issue(12'hB00);
        run_seq(1, 9, n);
        total++; if (stall_cnt !== 1) begin bad++; $display("FAIL starve_stall_cycles got=%0d want=1", stall_cnt); end
        total++; if (n !== 11) begin bad++; $display("FAIL starve_latency got=%0d want=11", n); end
        total++; if (rsp_data !== 64'h00000001_00000010) begin bad++; $display("FAIL starve_data got=%h want=%h", rsp_data, 64'h00000001_00000010); end
        consume();
    endtask
`endif

    task automatic test_rsp_hold();
        int n;
        setup(12'hB02, 32'hA5A5_0001, 32'h1, 32'h0BAD_F00D, 0);
        issue(12'hB02);
        run_seq(1000, 0, n);
        for (int c = 0; c < 3; c++) begin
            tick();
            total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL hold_valid[%0d] got=%0b want=1", c, rsp_valid); end
            total++; if (rsp_data !== 64'hA5A50001_0BADF00D) begin bad++; $display("FAIL hold_data[%0d] got=%h want=%h", c, rsp_data, 64'hA5A50001_0BADF00D); end
            total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL hold_err[%0d] got=%0b want=0", c, rsp_err); end
        end
        consume();
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        setup(12'hB00, 32'h3, 32'h1, 32'h44, 0);
        issue(12'hB00);
        tick();
        rst = 1'b1;
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%0b want=0", rsp_valid); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready got=%0b want=0", req_ready); end
        tick();
        rst   = 1'b0;
        armed = 1'b0;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready_after got=%0b want=1", req_ready); end
        for (int c = 0; c < 6; c++) begin
            tick();
            if (rsp_valid) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL midrst_stale_rsp got=%0d want=0", seen); end
        total++; if (rsp_data !== 64'h0) begin bad++; $display("FAIL midrst_data got=%h want=0", rsp_data); end
    endtask

    task automatic test_random();
        int n, lat, s, len, d;
        logic [63:0] ed;
        logic ee;
        logic [AW-1:0] a;
        logic [31:0] core_exp;
        for (int it = 0; it < 25; it++) begin
            a = 12'hB00 | AW'($urandom_range(0, 31));
            setup(a, $urandom, $urandom | 32'h1, $urandom, int'($urandom_range(0, 5)));
            expect_snap(ed, ee, lat);
            s   = int'($urandom_range(1, 2));
            len = int'($urandom_range(0, 4));
            d   = int'($urandom_range(0, 3));
            core_exp = (lo_a == 12'hB04) ? lo_v : 32'hC0DE0B04;
            issue(a);
            run_seq(s, len, n);
            total++; if (n !== lat + len) begin bad++; $display("FAIL rand%0d_latency got=%0d want=%0d", it, n, lat + len); end
            total++; if (rsp_data !== ed) begin bad++; $display("FAIL rand%0d_data got=%h want=%h", it, rsp_data, ed); end
            total++; if (rsp_err !== ee) begin bad++; $display("FAIL rand%0d_err got=%0b want=%0b", it, rsp_err, ee); end
            foreach (core_obs[i]) begin
                total++;
                if (core_obs[i] !== core_exp) begin bad++; $display("FAIL rand%0d_core[%0d] got=%h want=%h", it, i, core_obs[i], core_exp); end
            end
            for (int c = 0; c < d; c++) begin
                tick();
                total++;
                if (rsp_valid !== 1'b1 || rsp_data !== ed || rsp_err !== ee) begin
                    bad++;
                    $display("FAIL rand%0d_hold got=%0b/%h/%0b want=1/%h/%0b", it, rsp_valid, rsp_data, rsp_err, ed, ee);
                end
            end
            consume();
        end
    endtask

    initial begin
        rst        = 1'b1;
        core_ren   = 1'b0;
        core_raddr = '0;
        req_valid  = 1'b0;
        req_addr   = '0;
        rsp_ready  = 1'b0;
        armed      = 1'b0;
        reads_base = 0;
        lo_a       = 12'hB00;
        hi_a       = 12'hB80;
        lo_v       = '0;
        h0         = '0;
        step       = '0;
        k          = 0;
        test_reset();
        test_basic();
        test_retry_once();
        test_retry_exhaust();
        test_bad_addr();
        test_contention();
`ifdef CSR_ARB_STARVE_GUARD_EN
        test_starve();
`endif
        test_rsp_hold();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
